// File: rtl/sign_flag_monitor.sv
// Registered sample classifier: flags each accepted sample as negative/zero/positive
// and tracks consecutive and total negative counts with a sticky run-length alarm.
module sign_flag_monitor #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 8,
    parameter int RUN_LIMIT = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             VALID_IN,
    input  logic [WIDTH-1:0] A,
    input  logic             SIGNED_MODE,
    input  logic             CLR,
    output logic             VALID_OUT,
    output logic             NEG,
    output logic             ZERO,
    output logic             POS,
    output logic [CNT_W-1:0] NEG_RUN,
    output logic [CNT_W-1:0] NEG_TOTAL,
    output logic             ALARM
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(RUN_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ALARM
    } state_t;

    state_t state;

    logic             sample_neg;
    logic             sample_zero;
    logic [CNT_W-1:0] run_inc;
    logic [CNT_W-1:0] total_inc;

    always_comb begin
        sample_neg  = SIGNED_MODE & A[WIDTH-1];
        sample_zero = (A == '0);
        run_inc     = (NEG_RUN == CNT_MAX) ? NEG_RUN : NEG_RUN + 1'b1;
        total_inc   = (NEG_TOTAL == CNT_MAX) ? NEG_TOTAL : NEG_TOTAL + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            VALID_OUT <= 1'b0;
            NEG       <= 1'b0;
            ZERO      <= 1'b0;
            POS       <= 1'b0;
            NEG_RUN   <= '0;
            NEG_TOTAL <= '0;
            ALARM     <= 1'b0;
        end else begin
            VALID_OUT <= VALID_IN;

            // Flags follow every accepted sample, even one that CLR keeps out of the counters.
            if (VALID_IN) begin
                NEG  <= sample_neg;
                ZERO <= sample_zero;
                POS  <= !sample_neg && !sample_zero;
            end

            if (CLR) begin
                state     <= S_IDLE;
                NEG_RUN   <= '0;
                NEG_TOTAL <= '0;
                ALARM     <= 1'b0;
            end else if (VALID_IN) begin
                if (sample_neg) begin
                    NEG_RUN   <= run_inc;
                    NEG_TOTAL <= total_inc;
                    // NEG_RUN is 0 in S_IDLE, so the same limit test covers RUN_LIMIT=1.
                    case (state)
                        S_IDLE, S_RUN: begin
                            if (run_inc == LIMIT) begin
                                state <= S_ALARM;
                                ALARM <= 1'b1;
                            end else begin
                                state <= S_RUN;
                            end
                        end
                        S_ALARM: state <= S_ALARM;
                        default: begin
                            state <= S_IDLE;
                            ALARM <= 1'b0;
                        end
                    endcase
                end else begin
                    NEG_RUN <= '0;
                    if (state == S_RUN) begin
                        state <= S_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sign_flag_monitor.sv
// Directed-vector bench for sign_flag_monitor (WIDTH=8, CNT_W=8, RUN_LIMIT=4).
module tb_sign_flag_monitor;

    logic       CLK;
    logic       RST_N;
    logic       VALID_IN;
    logic [7:0] A;
    logic       SIGNED_MODE;
    logic       CLR;
    logic       VALID_OUT;
    logic       NEG;
    logic       ZERO;
    logic       POS;
    logic [7:0] NEG_RUN;
    logic [7:0] NEG_TOTAL;
    logic       ALARM;

    int unsigned n_cmp;
    int unsigned n_fail;

    sign_flag_monitor #(
        .WIDTH    (8),
        .CNT_W    (8),
        .RUN_LIMIT(4)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .VALID_IN   (VALID_IN),
        .A          (A),
        .SIGNED_MODE(SIGNED_MODE),
        .CLR        (CLR),
        .VALID_OUT  (VALID_OUT),
        .NEG        (NEG),
        .ZERO       (ZERO),
        .POS        (POS),
        .NEG_RUN    (NEG_RUN),
        .NEG_TOTAL  (NEG_TOTAL),
        .ALARM      (ALARM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       v;
        logic [7:0] a;
        logic       s;
        logic       c;
        logic       vo;
        logic       n;
        logic       z;
        logic       p;
        logic [7:0] run;
        logic [7:0] tot;
        logic       al;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic vo, input logic n, input logic z,
                         input logic p, input logic [7:0] run, input logic [7:0] tot,
                         input logic al);
        n_cmp++;
        if ({VALID_OUT, NEG, ZERO, POS, NEG_RUN, NEG_TOTAL, ALARM} !== {vo, n, z, p, run, tot, al}) begin
            n_fail++;
            $display("FAIL %s: got vo=%b n=%b z=%b p=%b run=%0d tot=%0d al=%b, expected vo=%b n=%b z=%b p=%b run=%0d tot=%0d al=%b",
                     name, VALID_OUT, NEG, ZERO, POS, NEG_RUN, NEG_TOTAL, ALARM,
                     vo, n, z, p, run, tot, al);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic v, input logic [7:0] a, input logic s, input logic c);
        VALID_IN    = v;
        A           = a;
        SIGNED_MODE = s;
        CLR         = c;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        RST_N       = 1'b0;
        VALID_IN    = 1'b1;
        A           = 8'h80;
        SIGNED_MODE = 1'b1;
        CLR         = 1'b0;

        //            v  a      s  c  vo n  z  p  run tot al
        tbl[0]  = '{1, 8'h80, 1, 0, 1, 1, 0, 0, 1, 1, 0};
        tbl[1]  = '{0, 8'h80, 1, 0, 0, 1, 0, 0, 1, 1, 0};
        tbl[2]  = '{1, 8'h01, 1, 0, 1, 0, 0, 1, 0, 1, 0};
        tbl[3]  = '{1, 8'h00, 1, 1, 1, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{1, 8'hFF, 1, 0, 1, 1, 0, 0, 1, 1, 0};
        tbl[5]  = '{1, 8'hFE, 1, 0, 1, 1, 0, 0, 2, 2, 0};
        tbl[6]  = '{1, 8'hFD, 1, 0, 1, 1, 0, 0, 3, 3, 0};
        tbl[7]  = '{1, 8'hFC, 1, 0, 1, 1, 0, 0, 4, 4, 1};
        tbl[8]  = '{1, 8'h05, 1, 0, 1, 0, 0, 1, 0, 4, 1};
        tbl[9]  = '{1, 8'hFF, 0, 0, 1, 0, 0, 1, 0, 4, 1};
        tbl[10] = '{0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[11] = '{1, 8'hFF, 1, 0, 1, 1, 0, 0, 1, 1, 0};
        tbl[12] = '{1, 8'hFF, 1, 0, 1, 1, 0, 0, 2, 2, 0};
        tbl[13] = '{0, 8'h00, 1, 0, 0, 1, 0, 0, 2, 2, 0};
        tbl[14] = '{0, 8'h00, 1, 0, 0, 1, 0, 0, 2, 2, 0};
        tbl[15] = '{0, 8'h00, 1, 0, 0, 1, 0, 0, 2, 2, 0};
        tbl[16] = '{1, 8'hFF, 1, 0, 1, 1, 0, 0, 3, 3, 0};
        tbl[17] = '{1, 8'hFF, 1, 0, 1, 1, 0, 0, 4, 4, 1};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_state", 0, 0, 0, 0, 8'd0, 8'd0, 0);
        RST_N = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].s, tbl[i].c);
            check($sformatf("vec%0d", i), tbl[i].vo, tbl[i].n, tbl[i].z, tbl[i].p,
                  tbl[i].run, tbl[i].tot, tbl[i].al);
        end

        // Non-negative signed sweep: run cleared, total and alarm untouched.
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0);
            check($sformatf("sweep%0d", i), 1, 0, (i == 0), (i != 0), 8'd0, 8'd4, 1);
        end
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check("unsigned_ff", 1, 0, 0, 1, 8'd0, 8'd4, 1);

        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("clr_idle", 0, 0, 0, 1, 8'd0, 8'd0, 0);

        for (int i = 0; i < 300; i++) begin
            logic [7:0] e;
            e = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            step(1'b1, 8'h9C, 1'b1, 1'b0);
            check($sformatf("sat%0d", i), 1, 1, 0, 0, e, e, (i + 1 >= 4));
        end

        step(1'b1, 8'hFF, 1'b1, 1'b1);
        check("clr_with_neg", 1, 1, 0, 0, 8'd0, 8'd0, 0);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hF0, 1'b1, 1'b0);
        end
        check("pre_reset_alarm", 1, 1, 0, 0, 8'd4, 8'd4, 1);

        RST_N = 1'b0;
        step(1'b1, 8'hF0, 1'b1, 1'b0);
        check("reset_in_alarm", 0, 0, 0, 0, 8'd0, 8'd0, 0);
        RST_N = 1'b1;
        step(1'b1, 8'hF0, 1'b1, 1'b0);
        check("after_reset_neg", 1, 1, 0, 0, 8'd1, 8'd1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sign_flag_monitor.md
# sign_flag_monitor

Registered, parametrised successor to the combinational less-than-zero detector. It classifies a stream of WIDTH-bit samples as negative, zero or positive, in either signed or unsigned interpretation. It tracks consecutive-negative runs and a total negative count, and raises a sticky alarm when a run reaches a programmable limit. It sits after ALU/datapath result registers as a status and diagnostics block.

## Interface
- WIDTH, 8: sample width in bits (>= 2).
- CNT_W, 8: width of both counters (>= 2).
- RUN_LIMIT, 4: run length that triggers ALARM (1 .. 2^CNT_W-1).
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, synchronous and active-low.
- VALID_IN  input  1  A is a valid sample this cycle.
- A  input  WIDTH  sample.
- SIGNED_MODE  input  1  1 = two's complement, 0 = unsigned; sampled with A.
- CLR  input  1  synchronous clear of counters, FSM and ALARM.
- VALID_OUT  output  1  flags below reflect a newly accepted sample.
- NEG  output  1  last accepted sample < 0.
- ZERO  output  1  last accepted sample == 0.
- POS  output  1  last accepted sample > 0.
- NEG_RUN  output  CNT_W  current consecutive-negative count, saturating.
- NEG_TOTAL  output  CNT_W  total negative samples since reset/CLR, saturating.
- ALARM  output  1  sticky; set when NEG_RUN reaches RUN_LIMIT.

## Operation
- Classification of an accepted sample (VALID_IN=1):
  - neg = SIGNED_MODE & A[WIDTH-1].
  - zero = (A == 0).
  - pos = !neg & !zero.
  - Exactly one of NEG/ZERO/POS is 1 after the first accepted sample.
- With VALID_IN=0, NEG/ZERO/POS hold their values and the counters hold.
- FSM states:
  - S_IDLE: no active run.
  - S_RUN: 0 < NEG_RUN < RUN_LIMIT.
  - S_ALARM: ALARM=1.
- Transitions on accepted samples:
  - S_IDLE: neg with RUN_LIMIT=1 -> S_ALARM; other neg -> S_RUN; non-neg -> stay.
  - S_RUN: neg making NEG_RUN == RUN_LIMIT -> S_ALARM; other neg -> stay; non-neg -> S_IDLE.
  - S_ALARM: leaves only on CLR or reset, then goes to S_IDLE.
- NEG_RUN:
  - Increments on neg, saturating at 2^CNT_W-1.
  - Reset to 0 on a non-neg sample, in all states including S_ALARM.
- NEG_TOTAL: increments on neg, saturating at 2^CNT_W-1. It is never reset by a non-neg sample.
- ALARM is 1 exactly in S_ALARM. It does not drop when the run ends.
- CLR:
  - Forces NEG_RUN=0, NEG_TOTAL=0 and ALARM=0, and puts the FSM in S_IDLE.
  - CLR overrides a simultaneous sample for counters and FSM: that sample is not counted.
  - NEG/ZERO/POS/VALID_OUT still update from that sample.
- Reset (RST_N=0 at a rising edge) takes priority over everything, including mid-run and in S_ALARM.
- Reset values:
  - VALID_OUT=0, NEG=0, ZERO=0, POS=0.
  - NEG_RUN=0, NEG_TOTAL=0, ALARM=0.
  - FSM in S_IDLE.

## Timing
- Latency is 1 cycle. A sample accepted at edge k drives VALID_OUT, the flags, the counters and ALARM after edge k.
- VALID_OUT is a 1-cycle pulse per accepted sample, equal to VALID_IN delayed by one cycle. It is 0 in the cycle after reset.
- Back-to-back samples are accepted every cycle. There is no backpressure.
- ALARM rises in the same cycle that NEG_RUN first shows RUN_LIMIT.
- A SIGNED_MODE change takes effect on the next accepted sample. Already-registered flags are not re-evaluated.
- Saturation: at 2^CNT_W-1 a further neg leaves the value unchanged. There is no wrap-around.
- All outputs are registers. No combinational path runs from inputs to outputs.

## Test plan
- Reset, then A=0x80, SIGNED_MODE=1, VALID_IN=1 for 1 cycle.
  - Required: next cycle VALID_OUT=1, NEG=1, NEG_RUN=1, NEG_TOTAL=1, ALARM=0.
  - Required: the following cycle VALID_OUT=0 and all values held.
- Signed sweep A=0..99 (WIDTH=8): NEG=0 throughout, ZERO=1 only for A=0. Then A=0xFF with SIGNED_MODE=0: POS=1, NEG=0, counters unchanged.
- Samples -1,-2,-3,-4,+5 with RUN_LIMIT=4:
  - Required: NEG_RUN reads 1,2,3,4,0.
  - Required: ALARM rises with NEG_RUN=4 and stays 1 after +5.
  - Required: NEG_TOTAL=4.
- Drive 300 consecutive negatives with CNT_W=8:
  - Required: NEG_RUN and NEG_TOTAL saturate at 255 and never wrap.
  - Then CLR together with a negative sample: counters=0, ALARM=0, NEG=1.
- Samples -1,-1, then VALID_IN=0 for 3 cycles, then -1,-1:
  - Required: gaps do not break the run; NEG_RUN=4 and ALARM=1.
- Reach S_ALARM, then assert RST_N=0 for 1 cycle while VALID_IN=1:
  - Required: all outputs at reset values next cycle.
  - Required: the next negative gives NEG_RUN=1.
